lfsr_10_seq: RTL and testbench
==============================

# lfsr_10_seq

Sequencer and stream front-end for the 10-bit maximal-length LFSR (polynomial x^10+x^7+1, period 1023).
- Accepts a seed and a word count, loads the LFSR, and emits the requested number of pseudo-random words on a valid/ready stream.
- Flags when the sequence wraps back to its seed, and substitutes 10'd1 for the illegal all-zero seed.
- Sits between a command source (CPU register block or test sequencer) and any consumer of the pseudo-random words (BIST pattern source, scrambler).

## Interface
- CNT_W, 11: width of the word-count input and internal counter (max N = 2^CNT_W-1).
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_i  input  1  command strobe; sampled only in IDLE.
- seed_i  input  10  LFSR seed, captured with start_i.
- count_i  input  CNT_W  number of words N to emit, captured with start_i.
- abort_i  input  1  synchronous abort; effective in any non-IDLE state.
- data_o  output  10  current LFSR word.
- valid_o  output  1  data_o holds an unconsumed word.
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
- busy_o  output  1  high in RUN and DONE.
- done_o  output  1  one-cycle pulse: all N words accepted.
- wrap_o  output  1  qualifies data_o: word equals seed and word index > 0.
- zero_seed_o  output  1  sticky; set when a zero seed was replaced; cleared by the next start_i.

## Operation
- LFSR step (Fibonacci, left shift): next = {q[8:0], q[9]^q[6]}.
  - From 1: 1, 2, 4, 8, 16, 32, 64, 129, 258, 516, 9, …
- Word k (k = 0..N-1) is the LFSR state after k steps from the seed. Word 0 is the seed itself.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start_i=1, count_i>0: load LFSR with seed_i (or 10'd1 if seed_i==0), load remaining-counter with count_i, reset index counter → RUN.
  - IDLE, start_i=1, count_i==0: no words emitted → DONE. zero_seed_o is still updated.
  - RUN: valid_o=1.
    - On handshake: LFSR steps, remaining decrements, index increments.
    - Handshake while remaining==1 → DONE.
    - No handshake: LFSR, data_o and counters hold.
  - DONE: done_o=1 for exactly this cycle → IDLE.
  - abort_i in RUN or DONE → IDLE next cycle. No done_o; any pending word is dropped. abort_i has priority over handshake.
- start_i is ignored while busy_o=1.
- wrap_o = valid_o && (data_o == captured seed) && (index != 0).
  - Index counter is CNT_W+1 bits wide, so it cannot wrap within a run.
  - Seed register holds the substituted value (1 for a zero seed).
- Zero seed: the LFSR never holds 0.

## Timing
- Reset values: state IDLE; LFSR 10'd1, so data_o=10'd1; valid_o=0, busy_o=0, done_o=0, wrap_o=0, zero_seed_o=0; counters 0.
- Reset mid-run: immediate return to these values; no done_o.
- start_i sampled at edge t: valid_o=1 with word 0 from t+1 (latency 1 cycle).
- Throughput: 1 word/cycle with ready_i held high. N words occupy cycles t+1..t+N, and done_o=1 at t+N+1.
- Backpressure: while valid_o && !ready_i, data_o and wrap_o stay stable. valid_o never drops before a handshake, except on abort/reset.
- count_i==0: done_o=1 at t+1, valid_o stays 0.
- busy_o rises at t+1 and falls the cycle after done_o.
- A new start_i is accepted at the first IDLE cycle after done_o.
- data_o outside RUN: holds the last LFSR state; not qualified.

## Test plan
- Basic: seed 1, N=11, ready_i=1 → data_o 1,2,4,8,16,32,64,129,258,516,9 on 11 consecutive cycles; done_o one cycle after the last word; busy_o low one cycle later.
- Backpressure: seed 1, N=4, ready_i toggling 1,0,0,1,0,1,1 → accepted words exactly 1,2,4,8; data_o stable during stalls; done_o one cycle after the 4th handshake.
- Full period: seed 10'h155, N=1024, ready_i=1 → no repeated word in indices 0..1022; word 1023 == 10'h155 with wrap_o=1; wrap_o=0 on all other words.
- Zero seed and N=0:
  - seed 0, N=3 → words 1,2,4, zero_seed_o=1.
  - Then seed 5, N=0 → done_o at t+1 with no valid_o, zero_seed_o cleared.
- Abort / ignored start: seed 1, N=100; start_i pulsed again after 3 words (no effect); abort_i after 5 words → IDLE next cycle, valid_o=0, no done_o. A subsequent start with seed 2, N=2 → words 2,4.
- Reset mid-run: rst_n low during RUN stall → all outputs at reset values asynchronously; after release, a new run with seed 1, N=3 → words 1,2,4.

Source files
------------

// File: rtl/lfsr_10_seq.sv
// Sequencer around a 10-bit maximal-length LFSR (x^10 + x^7 + 1, period 1023):
// loads a seed, emits N words on a valid/ready stream and flags seed wrap-around.
//
//   state | meaning
//   IDLE  | waiting for start_i; data_o holds the last LFSR state
//   RUN   | valid_o high, one LFSR step per accepted word
//   DONE  | single-cycle done_o pulse, then back to IDLE
module lfsr_10_seq #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [9:0]       seed_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             abort_i,
    output logic [9:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             wrap_o,
    output logic             zero_seed_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [9:0]       lfsr;
    logic [9:0]       seed_q;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W:0]   index;
    logic             zero_seed;

    logic [9:0]       seed_eff;
    logic [9:0]       lfsr_step;
    logic             accept;
    logic             last_word;

    // The all-zero state is a lock-up state for this LFSR, so it is never loaded.
    assign seed_eff  = (seed_i == 10'd0) ? 10'd1 : seed_i;
    assign lfsr_step = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    assign accept    = (state == RUN) && ready_i && !abort_i;
    assign last_word = (remaining == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = (count_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_nxt = IDLE;
                end else if (accept && last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        valid_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state)
            RUN: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = !abort_i;
            end
            default: begin
                valid_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= 10'd1;
            seed_q    <= 10'd1;
            remaining <= '0;
            index     <= '0;
            zero_seed <= 1'b0;
        end else if (state == IDLE) begin
            if (start_i) begin
                zero_seed <= (seed_i == 10'd0);
                if (count_i != '0) begin
                    lfsr      <= seed_eff;
                    seed_q    <= seed_eff;
                    remaining <= count_i;
                    index     <= '0;
                end
            end
        end else if (accept) begin
            lfsr      <= lfsr_step;
            remaining <= remaining - CNT_W'(1);
            index     <= index + (CNT_W+1)'(1);
        end
    end

    // index is one bit wider than the count, so it never rolls back to zero in a run.
    assign data_o      = lfsr;
    assign wrap_o      = valid_o && (lfsr == seed_q) && (index != '0);
    assign zero_seed_o = zero_seed;

endmodule

// File: tb/tb_lfsr_10_seq.sv
// Directed bench for lfsr_10_seq: per-cycle vector table plus hand-written
// sequences for asynchronous reset and the full 1023-word period.
module tb_lfsr_10_seq;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [9:0]  seed_i;
    logic [10:0] count_i;
    logic        abort_i;
    logic [9:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;
    logic        done_o;
    logic        wrap_o;
    logic        zero_seed_o;

    int errors = 0;
    int checks = 0;

    lfsr_10_seq #(.CNT_W(11)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .seed_i      (seed_i),
        .count_i     (count_i),
        .abort_i     (abort_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .wrap_o      (wrap_o),
        .zero_seed_o (zero_seed_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [9:0]  seed;
        logic [10:0] count;
        logic        ready;
        logic        abort;
        logic        exp_valid;
        logic        chk_data;
        logic [9:0]  exp_data;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_wrap;
        logic        exp_zs;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input logic st, input logic [9:0] sd, input logic [10:0] cn,
                               input logic rd, input logic ab, input logic ev, input logic cd,
                               input logic [9:0] ed, input logic eb, input logic edn,
                               input logic ew, input logic ez);
        vec_t r;
        r.start = st; r.seed = sd; r.count = cn; r.ready = rd; r.abort = ab;
        r.exp_valid = ev; r.chk_data = cd; r.exp_data = ed; r.exp_busy = eb;
        r.exp_done = edn; r.exp_wrap = ew; r.exp_zs = ez;
        return r;
    endfunction

    // Inputs are applied right after the falling edge, outputs checked 1 ns later.
    task automatic apply(input vec_t r, input int idx);
        @(negedge clk);
        start_i = r.start; seed_i = r.seed; count_i = r.count;
        ready_i = r.ready; abort_i = r.abort;
        #1;
        check($sformatf("valid[%0d]", idx), int'(valid_o), int'(r.exp_valid));
        check($sformatf("busy[%0d]", idx), int'(busy_o), int'(r.exp_busy));
        check($sformatf("done[%0d]", idx), int'(done_o), int'(r.exp_done));
        check($sformatf("wrap[%0d]", idx), int'(wrap_o), int'(r.exp_wrap));
        check($sformatf("zero_seed[%0d]", idx), int'(zero_seed_o), int'(r.exp_zs));
        if (r.chk_data) check($sformatf("data[%0d]", idx), int'(data_o), int'(r.exp_data));
    endtask

    task automatic idle_inputs();
        start_i = 1'b0; seed_i = '0; count_i = '0; ready_i = 1'b0; abort_i = 1'b0;
    endtask

    initial begin
        int words1[11];
        logic seen[1024];
        int k;

        words1 = '{1, 2, 4, 8, 16, 32, 64, 129, 258, 516, 9};
        idle_inputs();
        rst_n = 1'b0;
        #23;
        rst_n = 1'b1;

        // basic: seed 1, N=11, ready held high
        vecs.push_back(v(1, 10'd1, 11'd11, 1, 0, 0, 1, 10'd1, 0, 0, 0, 0));
        for (int i = 0; i < 11; i++)
            vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'(words1[i]), 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // backpressure: ready 1,0,0,1,0,1,1
        vecs.push_back(v(1, 10'd1, 11'd4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 1, 10'd2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 1, 10'd2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 1, 10'd4, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd4, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd8, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // zero seed, then N=0 clears the sticky flag
        vecs.push_back(v(1, 10'd0, 11'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd1, 1, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd2, 1, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd4, 1, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(v(1, 10'd5, 11'd0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // ignored start while busy, abort after 5 words, then seed 2 N=2
        vecs.push_back(v(1, 10'd1, 11'd100, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd4, 1, 0, 0, 0));
        vecs.push_back(v(1, 10'd3, 11'd7, 1, 0, 1, 1, 10'd8, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd16, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 1, 1, 10'd32, 1, 0, 0, 0));
        vecs.push_back(v(1, 10'd2, 11'd2, 1, 0, 0, 1, 10'd32, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 10'd4, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) apply(vecs[i], i);
        idle_inputs();

        // asynchronous reset during a stalled run (zero seed so the sticky flag is set)
        @(negedge clk);
        start_i = 1'b1; seed_i = 10'd0; count_i = 11'd3; ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1 check("rst_pre_data", int'(data_o), 1);
        @(negedge clk);
        ready_i = 1'b0;
        #1 check("rst_stall_data", int'(data_o), 2);
        check("rst_stall_zs", int'(zero_seed_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", int'(valid_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_data", int'(data_o), 1);
        check("rst_zs", int'(zero_seed_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_wrap", int'(wrap_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("rst_no_done", int'(done_o), 0);
        start_i = 1'b1; seed_i = 10'd1; count_i = 11'd3; ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            check($sformatf("post_rst_valid[%0d]", i), int'(valid_o), 1);
            check($sformatf("post_rst_data[%0d]", i), int'(data_o), words1[i]);
        end
        @(negedge clk);
        #1 check("post_rst_done", int'(done_o), 1);
        idle_inputs();
        @(negedge clk);

        // full period: seed 0x155, N=1024
        foreach (seen[i]) seen[i] = 1'b0;
        start_i = 1'b1; seed_i = 10'h155; count_i = 11'd1024; ready_i = 1'b1;
        for (k = 0; k < 1024; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            if (k < 1023) begin
                check($sformatf("fp_unique[%0d]", k), int'(seen[data_o]), 0);
                check($sformatf("fp_nonzero[%0d]", k), int'(data_o != 10'd0), 1);
                check($sformatf("fp_wrap[%0d]", k), int'(wrap_o), 0);
                seen[data_o] = 1'b1;
            end else begin
                check("fp_last_data", int'(data_o), 'h155);
                check("fp_last_wrap", int'(wrap_o), 1);
                check("fp_last_valid", int'(valid_o), 1);
            end
        end
        @(negedge clk);
        #1;
        check("fp_done", int'(done_o), 1);
        check("fp_valid_after", int'(valid_o), 0);
        idle_inputs();
        @(negedge clk);
        #1 check("fp_busy_low", int'(busy_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
